// File: rtl/fmap_stream_loader_if.sv
// Valid/ready word stream feeding the feature-map loader.
// master = producer side, slave = loader side.
interface fmap_stream_loader_if #(
  parameter int DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;

  modport master (output in_data, output in_valid, output in_last, input  in_ready);
  modport slave  (input  in_data, input  in_valid, input  in_last, output in_ready);
endinterface

// File: rtl/fmap_stream_loader.sv
// Assembles a MAT_DIMENSION x MAT_DIMENSION FP32 map from a row-major stream and hands it to the max-pool.
// Optional macro FMAP_LOADER_RELU_EN: words with the sign bit set are stored as zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | one cycle after reset release
// FILL      | accepting words into mat_out[row][col], in_ready=1
// START     | one-cycle pool_start pulse, map valid, pool_finished ignored
// WAIT_POOL | map frozen and valid until pool_finished
module fmap_stream_loader #(
  parameter int DATAWIDTH     = 32,
  parameter int MAT_DIMENSION = 27,
  parameter int INDEX_WIDTH   = $clog2(MAT_DIMENSION)
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  fmap_stream_loader_if.slave                                    strm,
  output logic [MAT_DIMENSION-1:0][MAT_DIMENSION-1:0][DATAWIDTH-1:0] mat_out,
  output logic                                                   mat_valid,
  output logic                                                   pool_start,
  input  logic                                                   pool_finished,
  output logic                                                   frame_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    START     = 2'd2,
    WAIT_POOL = 2'd3
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(MAT_DIMENSION - 1);

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] row, col;
  logic                   accept;
  logic                   at_final;
  logic [DATAWIDTH-1:0]   wr_word;

  assign strm.in_ready = (state == FILL);
  assign accept        = strm.in_valid && (state == FILL);
  assign at_final      = (row == LAST_IDX) && (col == LAST_IDX);

`ifdef FMAP_LOADER_RELU_EN
  assign wr_word = strm.in_data[DATAWIDTH-1] ? '0 : strm.in_data;
`else
  assign wr_word = strm.in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = FILL;
      FILL:      if (accept && at_final) state_next = START;
      START:     state_next = WAIT_POOL;
      WAIT_POOL: if (pool_finished) state_next = FILL;
      default:   state_next = IDLE;
    endcase
  end

  // An early in_last abandons the partial frame; counters restart at [0][0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (at_final || strm.in_last) begin
        row <= '0;
        col <= '0;
      end else if (col == LAST_IDX) begin
        col <= '0;
        row <= row + INDEX_WIDTH'(1);
      end else begin
        col <= col + INDEX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mat_out <= '0;
    else if (accept) mat_out[row][col] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_err <= 1'b0;
    else if (accept && (strm.in_last != at_final)) frame_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_start <= 1'b0;
      mat_valid  <= 1'b0;
    end else begin
      pool_start <= (state_next == START);
      mat_valid  <= (state_next == START) || (state_next == WAIT_POOL);
    end
  end

endmodule
